rpn_postfix_converter: RTL

//  Parametrised shunting-yard converter: consumes an infix token stream, emits the equivalent postfix (RPN) stream.

---
 rtl/rpn_postfix_converter_if.sv | 22 ++
 rtl/rpn_postfix_converter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rpn_postfix_converter_if.sv
// Token bus between the infix source, the postfix converter and the RPN core.
// master = converter side; slave = the source/sink environment.
interface rpn_postfix_converter_if #(parameter int WIDTH = 32);
    logic             input_stb;
    logic [WIDTH-1:0] input_data;
    logic             is_input_operator;
    logic             input_ack;
    logic             output_stb;
    logic [WIDTH-1:0] output_data;
    logic             is_output_operator;
    logic             output_ack;

    modport master (
        input  input_stb, input_data, is_input_operator, output_ack,
        output input_ack, output_stb, output_data, is_output_operator
    );

    modport slave (
        output input_stb, input_data, is_input_operator, output_ack,
        input  input_ack, output_stb, output_data, is_output_operator
    );
endinterface

// File: rtl/rpn_postfix_converter.sv
// Shunting-yard infix->postfix converter; parentheses enabled by RPN_CONV_PAREN_EN.
// Latency: number in cycle N -> output_stb in N+2; input_ack 2 cycles after output_ack.
// Backpressure: output_stb/data held until output_ack; input held until input_ack pulse.
module rpn_postfix_converter #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    rpn_postfix_converter_if.master bus,
    output logic [CW-1:0]          stack_count,
    output logic                   overflow_err,
    output logic                   syntax_err
);
    typedef enum logic [2:0] {IDLE, CMP, EMIT, WAIT, PUSH, FLUSH, DONE} state_t;

    localparam int         IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] OP_EQ = 3'b100;
`ifdef RPN_CONV_PAREN_EN
    localparam logic [2:0] OP_LP = 3'b110;
    localparam logic [2:0] OP_RP = 3'b111;
`endif

    state_t           state, state_n, ret, ret_n;
    logic [2:0]       tok, tok_n;
    logic [2:0]       stack [DEPTH];
    logic [2:0]       top;
    logic [CW-1:0]    count_n;
    logic [WIDTH-1:0] out_data_n;
    logic             out_op_n, out_stb_n, in_ack_n, ovf_n, push_en;
`ifdef RPN_CONV_PAREN_EN
    logic             syn_n;
`endif

    function automatic logic [1:0] prec(input logic [2:0] c);
        case (c)
            3'b001, 3'b101: prec = 2'd2;
            3'b010, 3'b011: prec = 2'd1;
            default:        prec = 2'd0;
        endcase
    endfunction

    assign top = stack[IW'(stack_count - CW'(1))];

    always_comb begin
        state_n    = state;
        ret_n      = ret;
        tok_n      = tok;
        count_n    = stack_count;
        out_data_n = bus.output_data;
        out_op_n   = bus.is_output_operator;
        out_stb_n  = bus.output_stb;
        in_ack_n   = 1'b0;
        ovf_n      = overflow_err;
        push_en    = 1'b0;
`ifdef RPN_CONV_PAREN_EN
        syn_n      = syntax_err;
`endif
        case (state)
            IDLE: if (bus.input_stb && !bus.input_ack) begin
                tok_n = bus.input_data[2:0];
                if (!bus.is_input_operator) begin
                    out_data_n = bus.input_data;
                    out_op_n   = 1'b0;
                    ret_n      = DONE;
                    state_n    = EMIT;
                end else begin
                    case (bus.input_data[2:0])
                        3'b001, 3'b010, 3'b011, 3'b101: state_n = CMP;
                        OP_EQ:                          state_n = FLUSH;
`ifdef RPN_CONV_PAREN_EN
                        OP_LP:                          state_n = PUSH;
                        OP_RP:                          state_n = CMP;
`endif
                        default:                        state_n = DONE;
                    endcase
                end
            end
            CMP: begin
`ifdef RPN_CONV_PAREN_EN
                // ')' unwinds to the matching '(' which is dropped silently
                if (tok == OP_RP) begin
                    if (stack_count == '0) begin
                        syn_n   = 1'b1;
                        state_n = DONE;
                    end else if (top == OP_LP) begin
                        count_n = stack_count - CW'(1);
                        state_n = DONE;
                    end else begin
                        out_data_n = WIDTH'(top);
                        out_op_n   = 1'b1;
                        count_n    = stack_count - CW'(1);
                        ret_n      = CMP;
                        state_n    = EMIT;
                    end
                end else
`endif
                if (stack_count != '0 && prec(top) >= prec(tok)) begin
                    out_data_n = WIDTH'(top);
                    out_op_n   = 1'b1;
                    count_n    = stack_count - CW'(1);
                    ret_n      = CMP;
                    state_n    = EMIT;
                end else begin
                    state_n = PUSH;
                end
            end
            PUSH: begin
                if (stack_count == CW'(DEPTH)) begin
                    ovf_n = 1'b1;
                end else begin
                    push_en = 1'b1;
                    count_n = stack_count + CW'(1);
                end
                state_n = DONE;
            end
            FLUSH: begin
                if (stack_count != '0) begin
                    count_n = stack_count - CW'(1);
`ifdef RPN_CONV_PAREN_EN
                    if (top == OP_LP) syn_n = 1'b1;
                    else
`endif
                    begin
                        out_data_n = WIDTH'(top);
                        out_op_n   = 1'b1;
                        ret_n      = FLUSH;
                        state_n    = EMIT;
                    end
                end else begin
                    out_data_n = WIDTH'(OP_EQ);
                    out_op_n   = 1'b1;
                    ret_n      = DONE;
                    state_n    = EMIT;
                end
            end
            EMIT: begin
                out_stb_n = 1'b1;
                state_n   = WAIT;
            end
            WAIT: if (bus.output_ack) begin
                out_stb_n = 1'b0;
                state_n   = ret;
            end
            DONE: begin
                in_ack_n = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state                  <= IDLE;
            ret                    <= IDLE;
            tok                    <= '0;
            stack_count            <= '0;
            overflow_err           <= 1'b0;
            bus.output_data        <= '0;
            bus.is_output_operator <= 1'b0;
            bus.output_stb         <= 1'b0;
            bus.input_ack          <= 1'b0;
        end else begin
            state                  <= state_n;
            ret                    <= ret_n;
            tok                    <= tok_n;
            stack_count            <= count_n;
            overflow_err           <= ovf_n;
            bus.output_data        <= out_data_n;
            bus.is_output_operator <= out_op_n;
            bus.output_stb         <= out_stb_n;
            bus.input_ack          <= in_ack_n;
        end
    end

`ifdef RPN_CONV_PAREN_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) syntax_err <= 1'b0;
        else     syntax_err <= syn_n;
    end
`else
    assign syntax_err = 1'b0;
`endif

    // Stack storage needs no reset: stack_count alone defines what is valid
    always_ff @(posedge CLK) begin
        if (push_en) stack[IW'(stack_count)] <= tok;
    end
endmodule
